// File: rtl/bist_pattern_if.sv
// Netlist-facing and host-facing signals of the BIST pattern controller.
// The host/netlist side drives the master modport; the controller takes the slave modport.
interface bist_pattern_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 3,
    parameter int MISR_W = 8
);
    logic              start;
    logic              abort;
    logic [MISR_W-1:0] golden;
    logic [OUT_W-1:0]  dut_resp;
    logic [IN_W-1:0]   stim;
    logic              stim_valid;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [15:0]       pattern_cnt;

    modport master (
        output start, abort, golden, dut_resp,
        input  stim, stim_valid, busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, abort, golden, dut_resp,
        output stim, stim_valid, busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: LFSR stimulus into a combinational netlist, MISR compaction of
// its response, and a golden-signature compare at the end of a fixed-length run.
//
// state | meaning
// IDLE  | waiting for start; stim held at 0
// RUN   | one counted pattern per cycle; MISR absorbs dut_resp, LFSR steps
// CMP   | single cycle: compare signature with golden
// DONE  | result held until start (rerun) or abort
module bist_pattern_ctrl #(
    parameter int                 IN_W       = 3,
    parameter int                 OUT_W      = 3,
    parameter int                 LFSR_W     = 8,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'hB8,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 8'h01,
    parameter int                 MISR_W     = 8,
    parameter logic [MISR_W-1:0]  MISR_TAPS  = 8'hB8,
    parameter logic [MISR_W-1:0]  MISR_SEED  = 8'h00,
    parameter int                 N_PATTERNS = 255
) (
    input logic           clk,
    input logic           rst_n,
    bist_pattern_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(N_PATTERNS - 1);

    logic [1:0]        state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [MISR_W-1:0] misr;
    logic [MISR_W-1:0] misr_next;
    logic [15:0]       cnt;
    logic              done_r;
    logic              pass_r;
    logic              load;

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
        misr_next = (misr >> 1) ^ (misr[0] ? MISR_TAPS : '0) ^ MISR_W'(bus.dut_resp);
    end

    // abort always beats start, including in IDLE
    assign load = bus.start && !bus.abort && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            lfsr   <= LFSR_SEED;
            misr   <= MISR_SEED;
            cnt    <= '0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else if (load) begin
            state  <= S_RUN;
            lfsr   <= LFSR_SEED;
            misr   <= MISR_SEED;
            cnt    <= '0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        lfsr <= lfsr_next;
                        misr <= misr_next;
                        cnt  <= cnt + 16'd1;
                        if (cnt == CNT_LAST) begin
                            state <= S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        pass_r <= (misr == bus.golden);
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        done_r <= 1'b0;
                        pass_r <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stim        = (state == S_RUN) ? lfsr[IN_W-1:0] : '0;
    assign bus.stim_valid  = (state == S_RUN);
    assign bus.busy        = (state == S_RUN) || (state == S_CMP);
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.signature   = misr;
    assign bus.pattern_cnt = cnt;
endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl: three instances with 6, 4 and 255 patterns.
module tb_bist_pattern_ctrl;
    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    bist_pattern_if #(.IN_W(3), .OUT_W(3), .MISR_W(8)) b6 ();
    bist_pattern_if #(.IN_W(3), .OUT_W(3), .MISR_W(8)) b4 ();
    bist_pattern_if #(.IN_W(3), .OUT_W(3), .MISR_W(8)) b255 ();

    bist_pattern_ctrl #(.N_PATTERNS(6))   u6   (.clk(clk), .rst_n(rst_n), .bus(b6));
    bist_pattern_ctrl #(.N_PATTERNS(4))   u4   (.clk(clk), .rst_n(rst_n), .bus(b4));
    bist_pattern_ctrl                     u255 (.clk(clk), .rst_n(rst_n), .bus(b255));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stim;
        logic        valid;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] cnt;
        logic [7:0]  sig;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cycles;
    int valid_cnt;
    logic [2:0] first_stim;

    initial begin
        // rows: after start edge k, one row per following cycle (6 RUN, CMP, DONE)
        vecs[0] = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 8'h00};
        vecs[1] = '{3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 8'h07};
        vecs[2] = '{3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 8'hBC};
        vecs[3] = '{3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 8'h59};
        vecs[4] = '{3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 8'h93};
        vecs[5] = '{3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 8'hF6};
        vecs[6] = '{3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd6, 8'h7C};
        vecs[7] = '{3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd6, 8'h7C};

        b6.start = 0;   b6.abort = 0;   b6.golden = 8'h7C;   b6.dut_resp = 3'b111;
        b4.start = 0;   b4.abort = 0;   b4.golden = 8'h93;   b4.dut_resp = 3'b111;
        b255.start = 0; b255.abort = 0; b255.golden = 8'h00; b255.dut_resp = 3'b000;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stim",  32'(b6.stim), 0);
        chk("rst_valid", 32'(b6.stim_valid), 0);
        chk("rst_busy",  32'(b6.busy), 0);
        chk("rst_done",  32'(b6.done), 0);
        chk("rst_pass",  32'(b6.pass), 0);
        chk("rst_sig",   32'(b6.signature), 32'h00);
        chk("rst_cnt",   32'(b6.pattern_cnt), 0);
        chk("rst_busy4", 32'(b4.busy), 0);
        @(negedge clk) rst_n = 1'b1;

        // reset in the middle of a run
        @(posedge clk); #1 b6.start = 1;
        @(posedge clk); #1 b6.start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_cnt_before_rst", 32'(b6.pattern_cnt), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b6.stim_valid), 0);
        chk("mid_rst_stim",  32'(b6.stim), 0);
        chk("mid_rst_busy",  32'(b6.busy), 0);
        chk("mid_rst_done",  32'(b6.done), 0);
        chk("mid_rst_cnt",   32'(b6.pattern_cnt), 0);
        chk("mid_rst_sig",   32'(b6.signature), 32'h00);
        @(negedge clk) rst_n = 1'b1;

        // full 6-pattern run, table driven
        @(posedge clk); #1 b6.start = 1;
        @(posedge clk); #1 b6.start = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t%0d_stim", i),  32'(b6.stim),        32'(vecs[i].stim));
            chk($sformatf("t%0d_valid", i), 32'(b6.stim_valid),  32'(vecs[i].valid));
            chk($sformatf("t%0d_busy", i),  32'(b6.busy),        32'(vecs[i].busy));
            chk($sformatf("t%0d_done", i),  32'(b6.done),        32'(vecs[i].done));
            chk($sformatf("t%0d_pass", i),  32'(b6.pass),        32'(vecs[i].pass));
            chk($sformatf("t%0d_cnt", i),   32'(b6.pattern_cnt), 32'(vecs[i].cnt));
            chk($sformatf("t%0d_sig", i),   32'(b6.signature),   32'(vecs[i].sig));
            @(posedge clk); #1;
        end
        chk("done_hold", 32'(b6.done), 1);
        chk("done_hold_cnt", 32'(b6.pattern_cnt), 6);

        // restart from DONE, then start pulsed during RUN is ignored
        b6.start = 1;
        @(posedge clk); #1 b6.start = 0;
        chk("restart_done_low", 32'(b6.done), 0);
        chk("restart_cnt0", 32'(b6.pattern_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        b6.start = 1;
        @(posedge clk); #1 b6.start = 0;
        chk("start_in_run_cnt", 32'(b6.pattern_cnt), 3);
        repeat (4) @(posedge clk);
        #1;
        chk("rerun_done", 32'(b6.done), 1);
        chk("rerun_pass", 32'(b6.pass), 1);
        chk("rerun_sig",  32'(b6.signature), 32'h7C);
        chk("rerun_cnt",  32'(b6.pattern_cnt), 6);

        // abort in DONE
        b6.abort = 1;
        @(posedge clk); #1 b6.abort = 0;
        chk("abort_done_done", 32'(b6.done), 0);
        chk("abort_done_pass", 32'(b6.pass), 0);
        chk("abort_done_sig",  32'(b6.signature), 32'h7C);
        chk("abort_done_cnt",  32'(b6.pattern_cnt), 6);

        // abort at RUN cycle 2, with start in the same cycle
        b6.start = 1;
        @(posedge clk); #1 b6.start = 0;
        repeat (2) @(posedge clk);
        #1;
        b6.abort = 1; b6.start = 1;
        @(posedge clk); #1 b6.abort = 0; b6.start = 0;
        chk("abort_run_busy",  32'(b6.busy), 0);
        chk("abort_run_valid", 32'(b6.stim_valid), 0);
        chk("abort_run_stim",  32'(b6.stim), 0);
        chk("abort_run_done",  32'(b6.done), 0);
        chk("abort_run_cnt",   32'(b6.pattern_cnt), 2);
        chk("abort_run_sig",   32'(b6.signature), 32'hBC);
        @(posedge clk); #1;
        chk("abort_stays_idle", 32'(b6.busy), 0);
        chk("abort_stays_cnt",  32'(b6.pattern_cnt), 2);

        // 4 patterns, resp=111, golden match then mismatch
        b4.start = 1;
        @(posedge clk); #1 b4.start = 0;
        cycles = 0;
        while (!b4.done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("n4_latency", 32'(cycles), 5);
        chk("n4_done", 32'(b4.done), 1);
        chk("n4_pass", 32'(b4.pass), 1);
        chk("n4_sig",  32'(b4.signature), 32'h93);
        chk("n4_cnt",  32'(b4.pattern_cnt), 4);

        b4.golden = 8'h92;
        b4.start = 1;
        @(posedge clk); #1 b4.start = 0;
        chk("n4_restart_done_low", 32'(b4.done), 0);
        cycles = 0;
        while (!b4.done && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("n4b_done", 32'(b4.done), 1);
        chk("n4b_pass", 32'(b4.pass), 0);
        chk("n4b_sig",  32'(b4.signature), 32'h93);

        // default 255 patterns, zero-response netlist
        b255.start = 1;
        @(posedge clk); #1 b255.start = 0;
        first_stim = b255.stim;
        cycles = 0;
        valid_cnt = 0;
        while (!b255.done && cycles < 400) begin
            if (b255.stim_valid) valid_cnt++;
            @(posedge clk); #1;
            cycles++;
        end
        chk("n255_first_stim", 32'(first_stim), 1);
        chk("n255_valid_cycles", 32'(valid_cnt), 255);
        chk("n255_done", 32'(b255.done), 1);
        chk("n255_pass", 32'(b255.pass), 1);
        chk("n255_sig",  32'(b255.signature), 32'h00);
        chk("n255_cnt",  32'(b255.pattern_cnt), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
